mem_rmw_ctrl: RTL and testbench
===============================

Name: mem_rmw_ctrl

Overview:
- Parametrised single-port word memory with a registered command handshake.
- Reads return word, bit, byte or halfword fields, zero-extended.
- Writes are full-word, or sub-word (byte or bit) via internal read-modify-write.
- Successor to the fixed 32x64K two-cycle memory; adds width and depth parameters, a halfword mode, sub-word writes, ready/valid flow control and a read-valid strobe.

Parameters:
- DATA_W, 32, word width; power of two, >= 16.
- ADDR_W, 16, address width; depth = 2**ADDR_W words.
- BIT_W, $clog2(DATA_W), bit-select width (derived).
- LANE_W, $clog2(DATA_W/8), byte-select width (derived).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- CmdValid  input  1  command present
- CmdReady  output  1  block can accept a command
- CmdOp  input  2  0=READ, 1=WRITE_WORD, 2=WRITE_BYTE, 3=WRITE_BIT
- RdMode  input  2  read extract: 0=word, 1=bit, 2=byte, 3=halfword
- Addr  input  ADDR_W  word address
- BitAddr  input  BIT_W  bit index for RdMode=1 / WRITE_BIT
- ByteAddr  input  LANE_W  byte lane; halfword index = ByteAddr[LANE_W-1:1]
- WrBus  input  DATA_W  write data; byte write uses [7:0], bit write uses [0]
- RdBus  output  DATA_W  read result, held until next read response
- RdValid  output  1  one-cycle strobe when RdBus updates

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, CmdReady=1, RdBus=0, RdValid=0, internal capture registers=0.
  - Memory contents are not cleared.
  - Asserting reset mid-operation aborts the op. A pending RMW write in that cycle is not committed.
- Accept: on a rising edge with CmdValid=1 and CmdReady=1. All command fields are captured at that edge.
- FSM states: IDLE, RD_RESP, RMW_WR.
- IDLE:
  - CmdReady=1.
  - WRITE_WORD: Mem[Addr]<=WrBus at the accept edge; stay IDLE (single-cycle, back-to-back allowed).
  - READ: word_q<=Mem[Addr]; go to RD_RESP.
  - WRITE_BYTE / WRITE_BIT: word_q<=Mem[Addr]; go to RMW_WR.
  - No CmdValid: stay IDLE.
- RD_RESP:
  - CmdReady=0.
  - Next edge: RdBus<=extract(word_q, mode_q), RdValid<=1, go to IDLE.
  - Latency: accept edge E; RdBus/RdValid valid after edge E+1.
- RMW_WR:
  - CmdReady=0.
  - Next edge: Mem[addr_q]<=merged word, go to IDLE.
  - Merged word = word_q with byte lane ByteAddr replaced by WrBus[7:0] (byte write), or bit BitAddr replaced by WrBus[0] (bit write). All other bits unchanged.
- Extract rules (all zero-extended to DATA_W):
  - word: word_q.
  - bit: word_q[BitAddr].
  - byte: word_q[8*ByteAddr +: 8].
  - halfword: word_q[16*hidx +: 16].
- RdValid is 0 in every cycle other than the single response cycle. RdBus is unchanged by writes.
- Ordering: a command accepted after an RMW observes the merged data. This holds because CmdReady stays low until the write edge.
- CmdValid while CmdReady=0: ignored. The source must hold it; it is not queued.
- Address wrap: Addr covers the full depth; no out-of-range case exists.
- Throughput:
  - WRITE_WORD: 1 per cycle.
  - READ, WRITE_BYTE, WRITE_BIT: 1 per 2 cycles.

Test Plan:
- Reset: hold reset=0 mid-read -> RdBus=0, RdValid=0, CmdReady=1 immediately (asynchronous); release, then READ -> completes normally.
- Word write then read: WRITE_WORD Addr=0x0010 WrBus=0xDEADBEEF, then READ RdMode=0 -> RdBus=0xDEADBEEF, RdValid high exactly one cycle, one edge after accept.
- Sub-field reads of 0xDEADBEEF:
  - byte ByteAddr=0 -> 0x000000EF; ByteAddr=3 -> 0x000000DE.
  - halfword ByteAddr=2 -> 0x0000DEAD.
  - bit BitAddr=4 -> 0; BitAddr=31 -> 1.
- RMW:
  - WRITE_BYTE ByteAddr=1 WrBus=0x55 on 0xDEADBEEF -> word reads 0xDEAD55EF.
  - Then WRITE_BIT BitAddr=0 WrBus=0 -> word reads 0xDEAD55EE.
- Handshake: hold CmdValid=1 with READ, READ, WRITE_WORD -> CmdReady pattern 1,0,1,0,1. Each command is accepted only when CmdReady=1; no command is dropped or duplicated.
- Parameter sweep: DATA_W=64, ADDR_W=4:
  - Write 0x0123456789ABCDEF to Addr=15 -> byte ByteAddr=7 = 0x01; halfword ByteAddr=6 = 0x0123.
  - Addr=0 unaffected.

Source files
------------

// File: rtl/mem_rmw_ctrl_if.sv
// mem_rmw_ctrl command/response bundle.
// Master drives commands; slave returns reads.
interface mem_rmw_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int LANE_W = $clog2(DATA_W / 8);

  logic              CmdValid;
  logic              CmdReady;
  logic [1:0]        CmdOp;
  logic [1:0]        RdMode;
  logic [ADDR_W-1:0] Addr;
  logic [BIT_W-1:0]  BitAddr;
  logic [LANE_W-1:0] ByteAddr;
  logic [DATA_W-1:0] WrBus;
  logic [DATA_W-1:0] RdBus;
  logic              RdValid;

  modport master (
    output CmdValid, CmdOp, RdMode, Addr,
    output BitAddr, ByteAddr, WrBus,
    input  CmdReady, RdBus, RdValid
  );

  modport slave (
    input  CmdValid, CmdOp, RdMode, Addr,
    input  BitAddr, ByteAddr, WrBus,
    output CmdReady, RdBus, RdValid
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Single-port word memory with sub-field reads
// and byte/bit writes via read-modify-write.
module mem_rmw_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int BIT_W  = $clog2(DATA_W),
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input logic           clk,
  input logic           reset,
  mem_rmw_ctrl_if.slave bus
);
  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_WORD = 2'd1;
  localparam logic [1:0] OP_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RD_RESP,
    RMW_WR
  } state_t;

  state_t state, stateNext;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [DATA_W-1:0] wordQ;
  logic [1:0]        modeQ;
  logic [1:0]        opQ;
  logic [ADDR_W-1:0] addrQ;
  logic [BIT_W-1:0]  bitQ;
  logic [LANE_W-1:0] byteQ;
  logic [7:0]        wrQ;

  logic              cmdReady;
  logic              accept;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdNext;
  logic [DATA_W-1:0] shifted;
  logic [LANE_W-1:0] hIdx;
  logic [DATA_W-1:0] rdBus;
  logic              rdValid;

  assign accept = bus.CmdValid && cmdReady;
  assign hIdx   = byteQ >> 1;

  assign bus.CmdReady = cmdReady;
  assign bus.RdBus    = rdBus;
  assign bus.RdValid  = rdValid;

  // State register; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state, handshake and memory write port.
  always_comb begin
    stateNext = state;
    cmdReady  = 1'b0;
    memWe     = 1'b0;
    memAddr   = bus.Addr;
    memData   = bus.WrBus;
    unique case (state)
      IDLE: begin
        cmdReady = 1'b1;
        if (bus.CmdValid) begin
          unique case (bus.CmdOp)
            OP_READ: stateNext = RD_RESP;
            OP_WORD: memWe = 1'b1;
            default: stateNext = RMW_WR;
          endcase
        end
      end
      RD_RESP: stateNext = IDLE;
      RMW_WR: begin
        stateNext = IDLE;
        memWe     = 1'b1;
        memAddr   = addrQ;
        memData   = merged;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Splice the new byte or bit into the fetched word.
  always_comb begin
    merged = wordQ;
    if (opQ == OP_BYTE) merged[{byteQ, 3'b000} +: 8] = wrQ;
    else                merged[bitQ] = wrQ[0];
  end

  // Zero-extended field extraction for read responses.
  always_comb begin
    rdNext  = '0;
    shifted = '0;
    unique case (modeQ)
      2'd0: rdNext = wordQ;
      2'd1: rdNext[0] = wordQ[bitQ];
      2'd2: begin
        shifted     = wordQ >> {byteQ, 3'b000};
        rdNext[7:0] = shifted[7:0];
      end
      2'd3: begin
        shifted      = wordQ >> {hIdx, 4'b0000};
        rdNext[15:0] = shifted[15:0];
      end
    endcase
  end

  // Capture the command and fetched word for two-cycle ops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wordQ <= '0;
      modeQ <= '0;
      opQ   <= '0;
      addrQ <= '0;
      bitQ  <= '0;
      byteQ <= '0;
      wrQ   <= '0;
    end else if (accept && bus.CmdOp != OP_WORD) begin
      wordQ <= mem[bus.Addr];
      modeQ <= bus.RdMode;
      opQ   <= bus.CmdOp;
      addrQ <= bus.Addr;
      bitQ  <= bus.BitAddr;
      byteQ <= bus.ByteAddr;
      wrQ   <= bus.WrBus[7:0];
    end
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  // Read response register and one-cycle strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdBus   <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= (state == RD_RESP);
      if (state == RD_RESP) rdBus <= rdNext;
    end
  end
endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: behavioural model,
// per-cycle compare, directed literals, random ops.
module tb_mem_rmw_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_rmw_ctrl_if #(.DATA_W(32), .ADDR_W(16)) A ();
  mem_rmw_ctrl_if #(.DATA_W(64), .ADDR_W(4))  B ();

  mem_rmw_ctrl #(.DATA_W(32), .ADDR_W(16)) dutA (
    .clk(clk), .reset(reset), .bus(A)
  );
  mem_rmw_ctrl #(.DATA_W(64), .ADDR_W(4)) dutB (
    .clk(clk), .reset(reset), .bus(B)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // ---- behavioural model of the 32-bit instance ----
  logic [31:0] mdlMem [logic [15:0]];
  bit          pendRd = 1'b0;
  logic [31:0] pendVal = '0;
  logic [31:0] expBus = '0;
  bit          expValid = 1'b0;
  bit          expReady = 1'b1;

  function automatic logic [31:0] ext(
    input logic [31:0] w, input logic [1:0] m,
    input int b, input int ln);
    case (m)
      2'd0: return w;
      2'd1: return (w >> b) & 32'h1;
      2'd2: return (w >> (8 * ln)) & 32'hFF;
      default: return (w >> (16 * (ln / 2))) & 32'hFFFF;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendRd   = 1'b0;
      expValid = 1'b0;
      expBus   = '0;
      expReady = 1'b1;
    end else begin
      bit acc;
      logic [31:0] w;
      int b, ln;
      acc = A.CmdValid && expReady;
      expValid = pendRd;
      if (pendRd) expBus = pendVal;
      pendRd = 1'b0;
      expReady = 1'b1;
      if (acc) begin
        b  = int'(A.BitAddr);
        ln = int'(A.ByteAddr);
        w  = mdlMem.exists(A.Addr) ? mdlMem[A.Addr] : '0;
        case (A.CmdOp)
          2'd0: begin
            pendRd   = 1'b1;
            pendVal  = ext(w, A.RdMode, b, ln);
            expReady = 1'b0;
          end
          2'd1: mdlMem[A.Addr] = A.WrBus;
          2'd2: begin
            w = (w & ~(32'hFF << (8 * ln)))
              | ((A.WrBus & 32'hFF) << (8 * ln));
            mdlMem[A.Addr] = w;
            expReady = 1'b0;
          end
          default: begin
            w = (w & ~(32'h1 << b)) | ((A.WrBus & 32'h1) << b);
            mdlMem[A.Addr] = w;
            expReady = 1'b0;
          end
        endcase
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("RdValid", 64'(A.RdValid), 64'(expValid));
    chk("RdBus", 64'(A.RdBus), 64'(expBus));
    chk("CmdReady", 64'(A.CmdReady), 64'(expReady));
  end

  // ---- drivers ----
  task automatic cmdA(input logic [1:0] op, input logic [1:0] md,
                      input logic [15:0] ad, input logic [4:0] bt,
                      input logic [1:0] ln, input logic [31:0] d);
    int n;
    n = 0;
    A.CmdValid = 1'b1;
    A.CmdOp = op; A.RdMode = md; A.Addr = ad;
    A.BitAddr = bt; A.ByteAddr = ln; A.WrBus = d;
    while (!A.CmdReady && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!A.CmdReady) begin
      total++;
      bad++;
      $display("FAIL cmdA_timeout: CmdReady=0 want 1");
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idleA();
    A.CmdValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rdA(input string nm, input logic [1:0] md,
                     input logic [15:0] ad, input logic [4:0] bt,
                     input logic [1:0] ln, input logic [31:0] req);
    cmdA(2'd0, md, ad, bt, ln, 32'h0);
    idleA();
    chk(nm, 64'(A.RdBus), 64'(req));
    chk("rdvalid_hi", 64'(A.RdValid), 64'd1);
    idleA();
    chk("rdvalid_lo", 64'(A.RdValid), 64'd0);
  endtask

  task automatic cmdB(input logic [1:0] op, input logic [1:0] md,
                      input logic [3:0] ad, input logic [2:0] ln,
                      input logic [63:0] d);
    int n;
    n = 0;
    B.CmdValid = 1'b1;
    B.CmdOp = op; B.RdMode = md; B.Addr = ad;
    B.BitAddr = '0; B.ByteAddr = ln; B.WrBus = d;
    while (!B.CmdReady && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!B.CmdReady) begin
      total++;
      bad++;
      $display("FAIL cmdB_timeout: CmdReady=0 want 1");
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic rdB(input string nm, input logic [1:0] md,
                     input logic [3:0] ad, input logic [2:0] ln,
                     input logic [63:0] req);
    cmdB(2'd0, md, ad, ln, 64'h0);
    B.CmdValid = 1'b0;
    @(negedge clk);
    chk(nm, B.RdBus, req);
    chk("b_rdvalid", 64'(B.RdValid), 64'd1);
    @(negedge clk);
  endtask

  logic [4:0] pat;

  initial begin
    A.CmdValid = 0; A.CmdOp = 0; A.RdMode = 0; A.Addr = 0;
    A.BitAddr = 0; A.ByteAddr = 0; A.WrBus = 0;
    B.CmdValid = 0; B.CmdOp = 0; B.RdMode = 0; B.Addr = 0;
    B.BitAddr = 0; B.ByteAddr = 0; B.WrBus = 0;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(A.CmdReady), 64'd1);
    chk("rst_valid", 64'(A.RdValid), 64'd0);
    chk("rst_bus", 64'(A.RdBus), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    cmdA(2'd1, 2'd0, 16'h0010, 5'd0, 2'd0, 32'hDEADBEEF);
    rdA("word", 2'd0, 16'h0010, 5'd0, 2'd0, 32'hDEADBEEF);
    rdA("byte0", 2'd2, 16'h0010, 5'd0, 2'd0, 32'h000000EF);
    rdA("byte3", 2'd2, 16'h0010, 5'd0, 2'd3, 32'h000000DE);
    rdA("half1", 2'd3, 16'h0010, 5'd0, 2'd2, 32'h0000DEAD);
    rdA("bit4", 2'd1, 16'h0010, 5'd4, 2'd0, 32'h0);
    rdA("bit31", 2'd1, 16'h0010, 5'd31, 2'd0, 32'h1);
    cmdA(2'd2, 2'd0, 16'h0010, 5'd0, 2'd1, 32'h55);
    rdA("rmw_byte", 2'd0, 16'h0010, 5'd0, 2'd0, 32'hDEAD55EF);
    cmdA(2'd3, 2'd0, 16'h0010, 5'd0, 2'd0, 32'h0);
    rdA("rmw_bit", 2'd0, 16'h0010, 5'd0, 2'd0, 32'hDEAD55EE);

    pat = '0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          pat = {pat[3:0], A.CmdReady};
          @(negedge clk);
        end
      end
      begin
        cmdA(2'd0, 2'd0, 16'h0010, 5'd0, 2'd0, 32'h0);
        cmdA(2'd0, 2'd2, 16'h0010, 5'd0, 2'd2, 32'h0);
        cmdA(2'd1, 2'd0, 16'h0020, 5'd0, 2'd0, 32'h12345678);
      end
    join
    idleA();
    chk("ready_pattern", 64'(pat), 64'(5'b10101));
    rdA("b2b_write", 2'd0, 16'h0020, 5'd0, 2'd0, 32'h12345678);

    cmdA(2'd0, 2'd0, 16'h0010, 5'd0, 2'd0, 32'h0);
    A.CmdValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_bus", 64'(A.RdBus), 64'd0);
    chk("midrst_valid", 64'(A.RdValid), 64'd0);
    chk("midrst_ready", 64'(A.CmdReady), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rdA("post_rst", 2'd0, 16'h0010, 5'd0, 2'd0, 32'hDEAD55EE);

    for (int a = 0; a < 8; a++)
      cmdA(2'd1, 2'd0, 16'(a), 5'd0, 2'd0, $urandom);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idleA();
      cmdA(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
           2'($urandom_range(0, 3)), $urandom);
    end
    idleA();
    idleA();
    idleA();

    cmdB(2'd1, 2'd0, 4'd0, 3'd0, 64'hAAAA5555_0F0FF0F0);
    cmdB(2'd1, 2'd0, 4'd15, 3'd0, 64'h01234567_89ABCDEF);
    rdB("b_byte7", 2'd2, 4'd15, 3'd7, 64'h01);
    rdB("b_half3", 2'd3, 4'd15, 3'd6, 64'h0123);
    rdB("b_word15", 2'd0, 4'd15, 3'd0, 64'h01234567_89ABCDEF);
    rdB("b_addr0", 2'd0, 4'd0, 3'd0, 64'hAAAA5555_0F0FF0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
